// File: rtl/seq_detect_pkg.sv
// Shared types and the default vector table for the sequence_detection self-test.
package seq_detect_pkg;

  localparam int VEC_W   = 8;
  localparam int IDX_W   = 4;
  localparam int MAX_VEC = 15;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    PULSE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  // Indices past the end of the table read as an all-zero vector.
  function automatic logic [VEC_W-1:0] default_vec(input logic [IDX_W-1:0] idx);
    logic [VEC_W-1:0] v;
    case (idx)
      4'd0:    v = 8'h25;
      4'd1:    v = 8'h29;
      4'd2:    v = 8'hB7;
      4'd3:    v = 8'h49;
      4'd4:    v = 8'h0D;
      4'd5:    v = 8'h25;
      4'd6:    v = 8'h56;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/seq_vector_rom.sv
// Combinational vector lookup for the self-test walker.
module seq_vector_rom
  import seq_detect_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [VEC_W-1:0] vec
);

  always_comb begin
    vec = default_vec(idx);
  end

endmodule

// File: rtl/seq_detect_sequencer.sv
// Self-test controller: walks the vector table into sequence_detection and checks led.
// state  | meaning
// IDLE   | waiting for start after reset
// LOAD   | drive vector idx onto det_switch
// SETTLE | hold switch stable for SETTLE_CYC cycles
// PULSE  | one-cycle det_button
// WAIT   | SAMPLE_CYC cycles for the detector to respond
// CHECK  | compare det_led with expected bit
// DONE   | result held until the next start
module seq_detect_sequencer
  import seq_detect_pkg::*;
#(
  parameter int          NUM_VEC    = 7,
  parameter int          SETTLE_CYC = 2,
  parameter int          SAMPLE_CYC = 10,
  parameter logic [14:0] EXPECT     = 15'h29
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [VEC_W-1:0] det_switch,
  output logic             det_button,
  input  logic             det_led,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W-1:0] fail_idx
);

  if (NUM_VEC < 1 || NUM_VEC > MAX_VEC) begin : g_bad_num_vec
    $error("NUM_VEC must be 1..15");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
    $error("SETTLE_CYC must be 1..255");
  end
  if (SAMPLE_CYC < 1 || SAMPLE_CYC > 255) begin : g_bad_sample
    $error("SAMPLE_CYC must be 1..255");
  end

  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [7:0]       SAMPLE_LOAD = 8'(SAMPLE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VEC - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [7:0]       cnt, cnt_n;
  logic [VEC_W-1:0] switch_n;
  logic             pass_n;
  logic [IDX_W-1:0] fail_idx_n;
  logic [VEC_W-1:0] rom_vec;

  seq_vector_rom u_rom (
    .idx (idx),
    .vec (rom_vec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      det_switch <= '0;
      pass       <= 1'b0;
      fail_idx   <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      det_switch <= switch_n;
      pass       <= pass_n;
      fail_idx   <= fail_idx_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    cnt_n      = cnt;
    switch_n   = det_switch;
    pass_n     = pass;
    fail_idx_n = fail_idx;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n    = LOAD;
          idx_n      = '0;
          pass_n     = 1'b0;
          fail_idx_n = '0;
        end
      end
      LOAD: begin
        switch_n = rom_vec;
        cnt_n    = SETTLE_LOAD;
        state_n  = SETTLE;
      end
      SETTLE: begin
        if (cnt == '0) state_n = PULSE;
        else           cnt_n   = cnt - 1'b1;
      end
      PULSE: begin
        cnt_n   = SAMPLE_LOAD;
        state_n = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_n = CHECK;
        else           cnt_n   = cnt - 1'b1;
      end
      CHECK: begin
        if (det_led != EXPECT[idx]) begin
          fail_idx_n = idx;
          pass_n     = 1'b0;
          state_n    = DONE;
        end else if (idx == LAST_IDX) begin
          pass_n  = 1'b1;
          state_n = DONE;
        end else begin
          idx_n   = idx + 1'b1;
          state_n = LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign det_button = (state == PULSE);
  assign done       = (state == DONE);
  assign busy       = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_seq_detect_sequencer.sv
// Directed bench: default-timing instance (a) and a fast-timing instance (b) with a detector model.
module tb_seq_detect_sequencer;

  localparam logic [14:0] EXP_BITS = 15'h29;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       led_a = 1'b0, led_b = 1'b0;
  logic [7:0] sw_a, sw_b;
  logic       btn_a, btn_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [3:0] fidx_a, fidx_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses_a = 0, pulses_b = 0;
  int inj_a = -1;
  int start_cyc_a = 0, start_cyc_b = 0;
  int last_b = -1;
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  logic [7:0] vec_tab [7] = '{8'h25, 8'h29, 8'hB7, 8'h49, 8'h0D, 8'h25, 8'h56};

  always #5 clk = ~clk;

  seq_detect_sequencer u_a (
    .clk        (clk),
    .rst        (rst),
    .start      (start_a),
    .det_switch (sw_a),
    .det_button (btn_a),
    .det_led    (led_a),
    .busy       (busy_a),
    .done       (done_a),
    .pass       (pass_a),
    .fail_idx   (fidx_a)
  );

  seq_detect_sequencer #(.SETTLE_CYC(1), .SAMPLE_CYC(1)) u_b (
    .clk        (clk),
    .rst        (rst),
    .start      (start_b),
    .det_switch (sw_b),
    .det_button (btn_b),
    .det_led    (led_b),
    .busy       (busy_b),
    .done       (done_b),
    .pass       (pass_b),
    .fail_idx   (fidx_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One cycle; outputs sampled at the falling edge, detector model reacts to each button pulse.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (btn_a) begin
      total++;
      assert (exp_q_a.size() != 0)
      else begin
        bad++;
        $error("FAIL a_unexpected_pulse observed=%0h expected=none", sw_a);
      end
      if (exp_q_a.size() != 0) check("a_switch", 32'(sw_a), 32'(exp_q_a.pop_front()));
      led_a = EXP_BITS[pulses_a] ^ (pulses_a == inj_a);
      pulses_a++;
    end
    if (btn_b) begin
      total++;
      assert (exp_q_b.size() != 0)
      else begin
        bad++;
        $error("FAIL b_unexpected_pulse observed=%0h expected=none", sw_b);
      end
      if (exp_q_b.size() != 0) check("b_switch", 32'(sw_b), 32'(exp_q_b.pop_front()));
      if (last_b >= 0) check("b_spacing", 32'(cyc - last_b), 32'd5);
      last_b = cyc;
      led_b = EXP_BITS[pulses_b];
      pulses_b++;
    end
  endtask

  task automatic run_a(input int inj, input int nexp);
    pulses_a = 0;
    inj_a    = inj;
    exp_q_a.delete();
    for (int i = 0; i < nexp; i++) exp_q_a.push_back(vec_tab[i]);
    start_a     = 1'b1;
    start_cyc_a = cyc;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int n = 0;
    while (!done_a && n < budget) begin
      tick();
      n++;
    end
    check("a_done_reached", 32'(done_a), 32'd1);
  endtask

  task automatic wait_pulses_a(input int target, input int budget);
    int n = 0;
    while (pulses_a < target && n < budget) begin
      tick();
      n++;
    end
    check("a_pulse_reached", 32'(pulses_a), 32'(target));
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_switch"}, 32'(sw_a), 32'd0);
    check({tag, "_button"}, 32'(btn_a), 32'd0);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_done"}, 32'(done_a), 32'd0);
    check({tag, "_pass"}, 32'(pass_a), 32'd0);
    check({tag, "_fail_idx"}, 32'(fidx_a), 32'd0);
  endtask

  task automatic check_pass_a(input string tag);
    check({tag, "_run_len"}, 32'(cyc - start_cyc_a - 1), 32'd105);
    check({tag, "_pass"}, 32'(pass_a), 32'd1);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_pulses"}, 32'(pulses_a), 32'd7);
    check({tag, "_queue_left"}, 32'(exp_q_a.size()), 32'd0);
    check({tag, "_switch_hold"}, 32'(sw_a), 32'h56);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check_idle_a("rst_a");
    check("rst_b_switch", 32'(sw_b), 32'd0);
    check("rst_b_busy", 32'(busy_b), 32'd0);

    // all-pass run
    run_a(-1, 7);
    check("t1_busy_after_start", 32'(busy_a), 32'd1);
    wait_done_a(200);
    check_pass_a("t1");

    // mismatch on vector 3
    run_a(3, 4);
    wait_done_a(200);
    check("t2_pass", 32'(pass_a), 32'd0);
    check("t2_fail_idx", 32'(fidx_a), 32'd3);
    check("t2_pulses", 32'(pulses_a), 32'd4);
    repeat (30) tick();
    check("t2_done_held", 32'(done_a), 32'd1);
    check("t2_no_more_pulses", 32'(pulses_a), 32'd4);
    check("t2_fail_idx_held", 32'(fidx_a), 32'd3);

    // restart from DONE after a fail clears the result flags
    run_a(-1, 7);
    check("t5_done_cleared", 32'(done_a), 32'd0);
    check("t5_pass_cleared", 32'(pass_a), 32'd0);
    check("t5_fail_idx_cleared", 32'(fidx_a), 32'd0);
    wait_done_a(200);
    check_pass_a("t5");

    // start while busy is ignored
    run_a(-1, 7);
    wait_pulses_a(3, 100);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("t3_busy", 32'(busy_a), 32'd1);
    wait_done_a(200);
    check_pass_a("t3");

    // reset in WAIT of vector 4, then a fresh run
    run_a(-1, 7);
    wait_pulses_a(5, 150);
    repeat (3) tick();
    check("t4_busy_pre_rst", 32'(busy_a), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_a("t4_rst");
    repeat (20) tick();
    check("t4_idle_pulses", 32'(pulses_a), 32'd5);
    run_a(-1, 7);
    wait_done_a(200);
    check_pass_a("t4");

    // fast timing instance
    pulses_b = 0;
    last_b   = -1;
    exp_q_b.delete();
    for (int i = 0; i < 7; i++) exp_q_b.push_back(vec_tab[i]);
    start_b     = 1'b1;
    start_cyc_b = cyc;
    tick();
    start_b = 1'b0;
    begin
      int n = 0;
      while (!done_b && n < 100) begin
        tick();
        n++;
      end
    end
    check("t6_done", 32'(done_b), 32'd1);
    check("t6_run_len", 32'(cyc - start_cyc_b - 1), 32'd35);
    check("t6_pass", 32'(pass_b), 32'd1);
    check("t6_pulses", 32'(pulses_b), 32'd7);
    check("t6_switch_hold", 32'(sw_b), 32'h56);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
